// File: rtl/pattern_pkg.sv
// Shared types and constants for the BBCBC serial pattern generator and its loopback checker.
package pattern_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // B=1, C=0: the frame B,B,C,B,C sent MSB first
  localparam logic       B_BIT     = 1'b1;
  localparam logic       C_BIT     = 1'b0;
  localparam logic [4:0] PAT_BBCBC = {B_BIT, B_BIT, C_BIT, B_BIT, C_BIT};
  localparam int         PAT_LEN   = 5;

endpackage

// File: rtl/pattern_gen_if.sv
// Control/status bundle of pattern_gen; det_count/mismatch exist only with PATTERN_GEN_CHECK_EN.
// Handshake: start is a request taken only while busy=0 (IDLE), reps is captured on that same
// edge; d/valid stream out with no backpressure; done marks the end of a completed burst.
interface pattern_gen_if
  import pattern_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic             start;
  logic [CNT_W-1:0] reps;
  logic             abort;
  logic             d;
  logic             valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] frames_sent;
  state_t           state;
`ifdef PATTERN_GEN_CHECK_EN
  logic [CNT_W-1:0] det_count;
  logic             mismatch;

  modport master (
    output start, reps, abort,
    input  d, valid, busy, done, frames_sent, state, det_count, mismatch
  );

  modport slave (
    input  start, reps, abort,
    output d, valid, busy, done, frames_sent, state, det_count, mismatch
  );
`else
  modport master (
    output start, reps, abort,
    input  d, valid, busy, done, frames_sent, state
  );

  modport slave (
    input  start, reps, abort,
    output d, valid, busy, done, frames_sent, state
  );
`endif

endinterface

// File: rtl/pattern_chk.sv
// Loopback detector: counts non-overlapping occurrences of PATTERN in the valid bits of a serial stream.
module pattern_chk #(
  parameter int               LEN     = 5,
  parameter logic [LEN-1:0]   PATTERN = 5'b11010,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [CNT_W-1:0] count
);

  localparam int FW = $clog2(LEN);

  logic [LEN-1:0] win;
  logic [LEN-1:0] shifted;
  logic [FW-1:0]  fill;
  logic           full;
  logic           hit;

  assign shifted = {win[LEN-2:0], bit_in};
  // full means LEN-1 bits are already held, so the incoming bit completes a window
  assign full    = (fill == FW'(LEN - 1));
  assign hit     = full && (shifted == PATTERN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win   <= '0;
      fill  <= '0;
      count <= '0;
    end else if (clear) begin
      win   <= '0;
      fill  <= '0;
      count <= '0;
    end else if (bit_valid) begin
      if (hit) begin
        // restart the window so matches never share bits
        win   <= '0;
        fill  <= '0;
        count <= count + CNT_W'(1);
      end else begin
        win  <= shifted;
        fill <= full ? fill : fill + FW'(1);
      end
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// Moore serial transmitter of REPS back-to-back PATTERN frames with GAP idle zeros between them.
// Optional loopback self-check under the PATTERN_GEN_CHECK_EN macro.
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int             LEN     = PAT_LEN,
  parameter logic [LEN-1:0] PATTERN = LEN'(PAT_BBCBC),
  parameter int             GAP     = 1,
  parameter int             CNT_W   = 8
) (
  input logic          clk,
  input logic          rst,
  pattern_gen_if.slave bus
);

  localparam int             IW      = $clog2(LEN);
  localparam logic [IW-1:0]  IDX_TOP = IW'(LEN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_nxt;
  logic [CNT_W-1:0] frames_sent;
  logic [CNT_W-1:0] reps_q;
  logic             accept;
  logic             frame_end;
  logic             last_frame;
  logic             gap_last;

  assign accept     = (state == IDLE) && bus.start;
  assign frame_end  = (state == SEND) && (idx == '0) && !bus.abort;
  assign last_frame = ((frames_sent + CNT_W'(1)) == reps_q);

  // Gap timer only exists when frames are separated by idle cycles
  if (GAP > 0) begin : g_gap
    localparam int GW = $clog2(GAP + 1);
    logic [GW-1:0] gap_cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        gap_cnt <= '0;
      end else if (state == pattern_pkg::GAP) begin
        gap_cnt <= gap_cnt + GW'(1);
      end else begin
        gap_cnt <= '0;
      end
    end

    assign gap_last = (gap_cnt == GW'(GAP - 1));
  end else begin : g_no_gap
    assign gap_last = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        // start is checked before abort, so a simultaneous abort is simply ignored here
        if (bus.start) begin
          if (bus.reps != '0) begin
            state_nxt = SEND;
            idx_nxt   = IDX_TOP;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      SEND: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (idx == '0) begin
          if (last_frame) begin
            state_nxt = DONE;
          end else if (GAP > 0) begin
            state_nxt = pattern_pkg::GAP;
          end else begin
            state_nxt = SEND;
            idx_nxt   = IDX_TOP;
          end
        end else begin
          idx_nxt = idx - IW'(1);
        end
      end
      pattern_pkg::GAP: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (gap_last) begin
          state_nxt = SEND;
          idx_nxt   = IDX_TOP;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frames_sent <= '0;
      reps_q      <= '0;
    end else if (accept) begin
      frames_sent <= '0;
      reps_q      <= bus.reps;
    end else if (frame_end) begin
      frames_sent <= frames_sent + CNT_W'(1);
    end
  end

  assign bus.d           = (state == SEND) ? PATTERN[idx] : 1'b0;
  assign bus.valid       = (state == SEND);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.frames_sent = frames_sent;
  assign bus.state       = state;

`ifdef PATTERN_GEN_CHECK_EN
  logic [CNT_W-1:0] det_count;
  logic             mismatch;

  pattern_chk #(
    .LEN     (LEN),
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .bit_in    (bus.d),
    .bit_valid (bus.valid),
    .count     (det_count)
  );

  // Every completed frame must have been seen by the detector by the time DONE is reached
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mismatch <= 1'b0;
    end else if (accept) begin
      mismatch <= 1'b0;
    end else if ((state == DONE) && (det_count != frames_sent)) begin
      mismatch <= 1'b1;
    end
  end

  assign bus.det_count = det_count;
  assign bus.mismatch  = mismatch;
`endif

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: directed scenarios plus random bursts checked against a frame-stream model.
module tb_pattern_gen;
  import pattern_pkg::*;

  localparam int             CNT_W = 8;
  localparam int             LEN   = 5;
  localparam int             GAP_C = 1;
  localparam logic [LEN-1:0] PAT   = 5'b11010;
  localparam int             EW    = 4 + CNT_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pattern_gen_if #(.CNT_W(CNT_W)) bus ();

  pattern_gen #(
    .LEN     (LEN),
    .PATTERN (PAT),
    .GAP     (GAP_C),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // per-cycle expectation: {busy, valid, d, done, frames_sent}
  logic [EW-1:0]  exp_q[$];
  logic [LEN-1:0] pat_v;
  int             tests_run    = 0;
  int             tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] ent(input bit b, input bit v, input bit dd, input bit dn,
                                        input int fs);
    logic [CNT_W-1:0] f;
    f = CNT_W'(fs);
    return {b, v, dd, dn, f};
  endfunction

  function automatic logic [EW-1:0] obs();
    return {bus.busy, bus.valid, bus.d, bus.done, bus.frames_sent};
  endfunction

  // Expected stream of a complete burst of r frames, followed by one idle cycle
  task automatic build_burst(input int r);
    exp_q.delete();
    for (int f = 0; f < r; f++) begin
      for (int b = LEN - 1; b >= 0; b--) exp_q.push_back(ent(1, 1, pat_v[b], 0, f));
      if (f < r - 1) for (int g = 0; g < GAP_C; g++) exp_q.push_back(ent(1, 0, 0, 0, f + 1));
    end
    exp_q.push_back(ent(1, 0, 0, 1, r));
    exp_q.push_back(ent(0, 0, 0, 0, r));
  endtask

  task automatic start_burst(input int r, input bit abort_too);
    @(negedge clk);
    bus.start = 1'b1;
    bus.reps  = CNT_W'(r);
    bus.abort = abort_too;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.reps  = CNT_W'($urandom_range(0, 255));
  endtask

  // abort_at < 0: no abort; otherwise abort is raised during that stream cycle
  task automatic run_burst(input int r, input int abort_at, input bit poke_start,
                           input bit abort_with_start);
    logic [EW-1:0] e;
    int            n;
    build_burst(r);
    start_burst(r, abort_with_start);
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("r%0d_cyc%0d", r, n), 32'(obs()), 32'(e));
      if (n == abort_at) begin
        exp_q.delete();
        exp_q.push_back(ent(0, 0, 0, 0, int'(e[CNT_W-1:0])));
        exp_q.push_back(ent(0, 0, 0, 0, int'(e[CNT_W-1:0])));
      end
      bus.abort = (n == abort_at);
      bus.start = (poke_start && exp_q.size() > 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      n++;
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
`ifdef PATTERN_GEN_CHECK_EN
    if (abort_at < 0) check($sformatf("det_count_r%0d", r), 32'(bus.det_count), 32'(r));
    check("mismatch", 32'(bus.mismatch), 32'd0);
`endif
  endtask

  initial begin
    int r;
    int ab;
    pat_v     = PAT;
    bus.start = 1'b0;
    bus.reps  = '0;
    bus.abort = 1'b0;
    rst       = 1'b1;
    #1 rst = 1'b0;

    // reset held for two cycles, outputs quiet during and after
    repeat (2) begin
      @(negedge clk);
      check("rst_hold", 32'(obs()), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_release", 32'(obs()), 32'd0);
    check("rst_state", 32'(bus.state), 32'(IDLE));

    run_burst(1, -1, 0, 0);
    run_burst(3, -1, 0, 0);
    run_burst(0, -1, 0, 0);
    // abort in frame 2 while its idx=3 bit is on d; start held high meanwhile
    run_burst(4, 7, 1, 0);
    // start and abort together: start wins
    run_burst(2, -1, 0, 1);

    // asynchronous reset in the middle of the first gap
    start_burst(3, 0);
    repeat (6) @(negedge clk);
    check("in_gap", 32'(bus.state), 32'(pattern_pkg::GAP));
    #2 rst = 1'b0;
    #1;
    check("async_rst", 32'(obs()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_burst(2, -1, 0, 0);

    for (int i = 0; i < 12; i++) begin
      r  = $urandom_range(0, 4);
      ab = -1;
      if (r > 0 && $urandom_range(0, 2) == 0)
        ab = $urandom_range(0, r * LEN + (r - 1) * GAP_C - 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_burst(r, ab, 1, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
